// File: rtl/user_au_fx_scheduler.sv
// Shares one external effect between the L/R channels. One sample is in flight at a time:
// round-robin grant, send to the effect, wait (with timeout) for the result, deliver it to its channel.
module user_au_fx_scheduler #(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [1:0][DataWidth-1:0] ch_data_i,
    input  logic [1:0]                ch_valid_i,
    output logic [1:0]                ch_ready_o,
    output logic [DataWidth-1:0]      fx_data_o,
    output logic                      fx_valid_o,
    input  logic                      fx_ready_i,
    input  logic [DataWidth-1:0]      fx_data_i,
    input  logic                      fx_valid_i,
    output logic                      fx_ready_o,
    output logic [1:0][DataWidth-1:0] out_data_o,
    output logic [1:0]                out_valid_o,
    input  logic [1:0]                out_ready_i,
    output logic                      busy_o,
    output logic                      timeout_o
);

    // state   | meaning
    // IDLE    | no sample in flight, may grant a channel
    // SEND    | captured sample offered to the effect
    // WAIT    | waiting for the processed sample, timeout counter running
    // DELIVER | processed sample offered to the tagged channel
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DELIVER
    } state_t;

    localparam int CntWidth = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TimeoutCycles);

    state_t                state_q;
    state_t                state_d;
    logic                  ptr_q;
    logic                  tag_q;
    logic [DataWidth-1:0]  sample_q;
    logic [DataWidth-1:0]  result_q;
    logic [CntWidth-1:0]   cnt_q;

    logic                  sel;
    logic                  grant;
    logic                  result_hit;
    logic                  timeout_hit;
    logic                  out_done;

    // A lone valid channel wins regardless of the pointer.
    assign sel = (&ch_valid_i) ? ptr_q : ch_valid_i[1];

    // rst_ni gating keeps ch_ready_o low while reset is held, even with valid inputs.
    assign grant       = rst_ni && enable_i && (|ch_valid_i) && (state_q == ST_IDLE);
    assign result_hit  = (state_q == ST_WAIT) && fx_valid_i;
    assign timeout_hit = (state_q == ST_WAIT) && !fx_valid_i && (cnt_q == CntLimit);
    assign out_done    = (state_q == ST_DELIVER) && out_ready_i[tag_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (fx_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (result_hit) begin
                    state_d = ST_DELIVER;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELIVER: begin
                if (out_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            tag_q    <= 1'b0;
            sample_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ptr_q    <= ~sel;
                tag_q    <= sel;
                sample_q <= ch_data_i[sel];
            end
            if (result_hit) begin
                result_q <= fx_data_i;
            end
            // Counter sits at zero outside WAIT, so WAIT always starts from a clean count.
            if (state_q != ST_WAIT) begin
                cnt_q <= '0;
            end else if (!fx_valid_i && (cnt_q != CntLimit)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ch_ready_o  = 2'b00;
        out_valid_o = 2'b00;
        out_data_o  = '0;
        if (grant) begin
            ch_ready_o[sel] = 1'b1;
        end
        if (state_q == ST_DELIVER) begin
            out_valid_o[tag_q] = 1'b1;
            out_data_o[tag_q]  = result_q;
        end
    end

    assign fx_valid_o = (state_q == ST_SEND);
    assign fx_data_o  = (state_q == ST_SEND) ? sample_q : '0;
    assign fx_ready_o = (state_q == ST_WAIT);
    assign busy_o     = (state_q != ST_IDLE);
    assign timeout_o  = timeout_hit;

endmodule

// File: doc/user_au_fx_scheduler.md
USER_AU_FX_SCHEDULER -- requirements
Module: user_au_fx_scheduler

Interface
REQ-001 SHALL have parameter DataWidth, default 32: width of every sample bus.
REQ-002 SHALL have parameter TimeoutCycles, default 1023: maximum WAIT cycles before a sample is dropped.
REQ-003 SHALL have port clk_i  input  1: the only clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst_ni  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port enable_i  input  1: permits new grants.
REQ-006 SHALL have port ch_data_i  input  2 x DataWidth: channel 0/1 (L/R) input samples.
REQ-007 SHALL have port ch_valid_i  input  2: per-channel sample valid.
REQ-008 SHALL have port ch_ready_o  output  2: per-channel accept.
REQ-009 SHALL have port fx_data_o  output  DataWidth: sample sent to the shared effect.
REQ-010 SHALL have port fx_valid_o  output  1: sample to the effect is valid.
REQ-011 SHALL have port fx_ready_i  input  1: the effect accepts the sample.
REQ-012 SHALL have port fx_data_i  input  DataWidth: processed sample from the effect.
REQ-013 SHALL have port fx_valid_i  input  1: processed sample is valid.
REQ-014 SHALL have port fx_ready_o  output  1: scheduler accepts the processed sample.
REQ-015 SHALL have port out_data_o  output  2 x DataWidth: per-channel processed sample.
REQ-016 SHALL have port out_valid_o  output  2: per-channel output valid.
REQ-017 SHALL have port out_ready_i  input  2: per-channel downstream ready.
REQ-018 SHALL have port busy_o  output  1: high in every state except IDLE.
REQ-019 SHALL have port timeout_o  output  1: one-cycle pulse when a sample is dropped.

Function
REQ-020 SHALL implement the FSM states IDLE, SEND, WAIT and DELIVER, with exactly one sample in flight at a time.
REQ-021 IDLE: when enable_i=1 and any ch_valid_i=1, SHALL select a channel, assert ch_ready_o for that channel only (combinationally), capture its data and tag, and go to SEND.
REQ-022 Arbitration SHALL be round-robin: the pointer resets to 0; if both channels are valid, the pointer channel wins; after every grant, the pointer SHALL point to the other channel.
REQ-023 If only one channel is valid, that channel SHALL win regardless of the pointer.
REQ-024 SEND: fx_valid_o=1 and fx_data_o=captured sample, both held stable until fx_ready_i=1; then go to WAIT.
REQ-025 WAIT: fx_ready_o=1; on fx_valid_i=1, capture fx_data_i and go to DELIVER.
REQ-026 fx_ready_o SHALL be 0 outside WAIT; fx_valid_i outside WAIT SHALL be ignored.
REQ-027 WAIT counter: SHALL be cleared on WAIT entry and increment each WAIT cycle without fx_valid_i.
REQ-028 Timeout: when the counter reaches TimeoutCycles, SHALL pulse timeout_o for 1 cycle, drop the sample and return to IDLE.
REQ-029 If fx_valid_i arrives in the same cycle the counter reaches TimeoutCycles, fx_valid_i SHALL win and no timeout SHALL occur.
REQ-030 DELIVER: out_valid_o[tag]=1 and out_data_o[tag]=result, both held until out_ready_i[tag]=1; then go to IDLE.
REQ-031 The non-tagged out_valid_o SHALL be 0; out_data_o SHALL be 0 for any channel whose out_valid_o=0.
REQ-032 Latency: grant in cycle N, fx_valid_o=1 in cycle N+1; result in cycle M, out_valid_o=1 in cycle M+1; return to IDLE the cycle after the output handshake.
REQ-033 Back-to-back: a new grant SHALL be possible in the first IDLE cycle after DELIVER.
REQ-034 enable_i=0 SHALL block new grants only; an in-flight transaction SHALL complete normally.
REQ-035 Samples SHALL pass through unmodified; no width conversion is performed.

Reset
REQ-036 On rst_ni=0, asynchronously: state=IDLE, pointer=0, counter=0, captured data=0; all outputs 0.
REQ-037 Reset asserted mid-transaction SHALL abandon the sample with no output and no timeout pulse.

Verification
REQ-038 Single channel: ch_valid_i=01, ch_data_i[0]=0x1234, effect returns 0x5678 after 3 cycles -> out_valid_o=01, out_data_o[0]=0x5678, total 1+1+3+1 cycles.
REQ-039 Contention: both channels valid for 4 transactions after reset -> grant order 0,1,0,1.
REQ-040 Backpressure: fx_ready_i=0 for 5 cycles -> fx_valid_o and fx_data_o stable throughout; out_ready_i low for 4 cycles -> out_valid_o and out_data_o held.
REQ-041 Timeout: TimeoutCycles=8 with no fx_valid_i -> timeout_o pulses once 8 cycles after WAIT entry; no out_valid_o; next grant accepted.
REQ-042 Timeout tie: fx_valid_i coincides with counter=8 -> result delivered, timeout_o stays 0.
REQ-043 Disable/reset: enable_i=0 in SEND -> transaction completes, no further grants; rst_ni=0 in WAIT -> all outputs 0 immediately.
